// File: rtl/multicycle_controller.sv
// Control FSM for the multicycle RV32I datapath: sequences fetch/decode/execute/memory/writeback
// with a mem_req/mem_ready handshake, a memory-stall timeout and an illegal-opcode trap.
module multicycle_controller #(
  parameter int unsigned MEM_WAIT_LIMIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       trap,
  output logic [3:0] state
);

  localparam logic [3:0] WAIT_LIMIT = 4'(MEM_WAIT_LIMIT);
  localparam logic       TIMEOUT_ON = (MEM_WAIT_LIMIT != 0);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECR    = 4'd6,
    EXECI    = 4'd7,
    ALUWB    = 4'd8,
    BEQ      = 4'd9,
    JAL      = 4'd10,
    JALRADR  = 4'd11,
    JALRJ    = 4'd12,
    UPPER    = 4'd13,
    TRAP     = 4'd14
  } ctrlState_t;

  ctrlState_t stateReg;
  ctrlState_t stateNext;
  logic [3:0] waitCntReg;
  logic       stall;
  logic       timeout;
  logic       pcUpdate;
  logic       branch;
  logic       irWriteEn;
  logic       memWriteEn;
  logic       regWriteEn;
  logic       memReqEn;

  assign stall   = (stateReg inside {FETCH, MEMREAD, MEMWRITE}) & ~mem_ready;
  assign timeout = TIMEOUT_ON & stall & (waitCntReg == WAIT_LIMIT);

  always_comb begin
    stateNext = stateReg;
    case (stateReg)
      FETCH:    if (mem_ready) stateNext = DECODE;
      DECODE: begin
        case (op)
          7'b0000011, 7'b0100011: stateNext = MEMADR;
          7'b0110011:             stateNext = EXECR;
          7'b0010011:             stateNext = EXECI;
          7'b1100011:             stateNext = BEQ;
          7'b1101111:             stateNext = JAL;
          7'b1100111:             stateNext = JALRADR;
          7'b0110111, 7'b0010111: stateNext = UPPER;
          default:                stateNext = TRAP;
        endcase
      end
      MEMADR:   stateNext = op[5] ? MEMWRITE : MEMREAD;
      MEMREAD:  if (mem_ready) stateNext = MEMWB;
      MEMWB:    stateNext = FETCH;
      MEMWRITE: if (mem_ready) stateNext = FETCH;
      EXECR:    stateNext = ALUWB;
      EXECI:    stateNext = ALUWB;
      ALUWB:    stateNext = FETCH;
      BEQ:      stateNext = FETCH;
      JAL:      stateNext = ALUWB;
      JALRADR:  stateNext = JALRJ;
      JALRJ:    stateNext = ALUWB;
      UPPER:    stateNext = ALUWB;
      TRAP:     stateNext = TRAP;
      default:  stateNext = TRAP;
    endcase
    // A stall that has used up its budget abandons the access instead of waiting again.
    if (timeout) stateNext = TRAP;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stateReg   <= FETCH;
      waitCntReg <= '0;
    end else begin
      stateReg <= stateNext;
      if (stateNext != stateReg) waitCntReg <= '0;
      else if (stall)            waitCntReg <= waitCntReg + 4'd1;
    end
  end

  always_comb begin
    memReqEn   = 1'b0;
    AdrSrc     = 1'b0;
    irWriteEn  = 1'b0;
    pcUpdate   = 1'b0;
    branch     = 1'b0;
    memWriteEn = 1'b0;
    regWriteEn = 1'b0;
    ResultSrc  = 2'b00;
    ALUSrcA    = 2'b00;
    ALUSrcB    = 2'b00;
    ALUOp      = 2'b00;
    trap       = 1'b0;
    case (stateReg)
      FETCH: begin
        memReqEn  = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        irWriteEn = mem_ready;
        pcUpdate  = mem_ready;
      end
      DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      MEMREAD: begin
        memReqEn = 1'b1;
        AdrSrc   = 1'b1;
      end
      MEMWB: begin
        ResultSrc  = 2'b01;
        regWriteEn = 1'b1;
      end
      MEMWRITE: begin
        memReqEn   = 1'b1;
        AdrSrc     = 1'b1;
        memWriteEn = mem_ready;
      end
      EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      ALUWB: regWriteEn = 1'b1;
      BEQ: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b01;
        branch  = 1'b1;
      end
      JAL: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcUpdate = 1'b1;
      end
      JALRADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      JALRJ: begin
        ALUSrcA  = 2'b01;
        ALUSrcB  = 2'b10;
        pcUpdate = 1'b1;
      end
      UPPER: begin
        ALUSrcA = op[5] ? 2'b11 : 2'b01;
        ALUSrcB = 2'b01;
      end
      TRAP:    trap = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    case (op)
      7'b0100011:             ImmSrc = 3'b001;
      7'b1100011:             ImmSrc = 3'b010;
      7'b1101111:             ImmSrc = 3'b011;
      7'b0110111, 7'b0010111: ImmSrc = 3'b100;
      default:                ImmSrc = 3'b000;
    endcase
  end

  // Reset gates every side-effecting strobe so an abandoned instruction cannot commit.
  assign PCWrite  = ~reset & (pcUpdate | (branch & zero));
  assign IRWrite  = ~reset & irWriteEn;
  assign RegWrite = ~reset & regWriteEn;
  assign MemWrite = ~reset & memWriteEn;
  assign mem_req  = ~reset & memReqEn;
  assign state    = stateReg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-cycle expectations are queued as stimulus is
// driven and checked against two instances (default timeout and MEM_WAIT_LIMIT=2) on the falling edge.
module tb_multicycle_controller;

  localparam int ST = 0, PCW = 1, IRW = 2, REGW = 3, MEMW = 4, MREQ = 5, TRP = 6;
  localparam int RES = 7, SRCA = 8, SRCB = 9, ALUOP = 10, IMM = 11, ADR = 12;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;

  logic       mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, trap;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic [3:0] state;

  logic       limMemReq, limAdrSrc, limIRWrite, limPCWrite, limMemWrite, limRegWrite, limTrap;
  logic [1:0] limResultSrc, limALUSrcA, limALUSrcB, limALUOp;
  logic [2:0] limImmSrc;
  logic [3:0] limState;

  multicycle_controller dut (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
    .MemWrite(MemWrite), .RegWrite(RegWrite), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .ImmSrc(ImmSrc), .trap(trap), .state(state)
  );

  multicycle_controller #(.MEM_WAIT_LIMIT(2)) dutLim (
    .clk(clk), .reset(reset), .op(op), .zero(zero), .mem_ready(mem_ready),
    .mem_req(limMemReq), .AdrSrc(limAdrSrc), .IRWrite(limIRWrite), .PCWrite(limPCWrite),
    .MemWrite(limMemWrite), .RegWrite(limRegWrite), .ResultSrc(limResultSrc),
    .ALUSrcA(limALUSrcA), .ALUSrcB(limALUSrcB), .ALUOp(limALUOp), .ImmSrc(limImmSrc),
    .trap(limTrap), .state(limState)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    string       tag;
    int          inst;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sbQueue[$];
  int   cycleNo = 0;
  int   nCompared = 0;
  int   nMismatch = 0;

  always @(posedge clk) cycleNo = cycleNo + 1;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] expVal);
    nCompared++;
    if (got !== expVal) begin
      nMismatch++;
      $display("FAIL %s: got %0d expected %0d", tag, got, expVal);
    end
  endtask

  function automatic string selName(input int sel);
    case (sel)
      ST: return "state"; PCW: return "PCWrite"; IRW: return "IRWrite";
      REGW: return "RegWrite"; MEMW: return "MemWrite"; MREQ: return "mem_req";
      TRP: return "trap"; RES: return "ResultSrc"; SRCA: return "ALUSrcA";
      SRCB: return "ALUSrcB"; ALUOP: return "ALUOp"; IMM: return "ImmSrc";
      ADR: return "AdrSrc"; default: return "?";
    endcase
  endfunction

  function automatic logic [31:0] obs(input int inst, input int sel);
    if (inst == 1) begin
      case (sel)
        ST: return 32'(limState); PCW: return 32'(limPCWrite); IRW: return 32'(limIRWrite);
        MREQ: return 32'(limMemReq); TRP: return 32'(limTrap); default: return 'x;
      endcase
    end
    case (sel)
      ST: return 32'(state); PCW: return 32'(PCWrite); IRW: return 32'(IRWrite);
      REGW: return 32'(RegWrite); MEMW: return 32'(MemWrite); MREQ: return 32'(mem_req);
      TRP: return 32'(trap); RES: return 32'(ResultSrc); SRCA: return 32'(ALUSrcA);
      SRCB: return 32'(ALUSrcB); ALUOP: return 32'(ALUOp); IMM: return 32'(ImmSrc);
      ADR: return 32'(AdrSrc); default: return 'x;
    endcase
  endfunction

  always @(negedge clk) begin
    while (sbQueue.size() > 0 && sbQueue[0].cyc == cycleNo) begin
      exp_t e;
      e = sbQueue.pop_front();
      checkVal($sformatf("%s%s.%s@%0d", e.tag, (e.inst == 1) ? "[lim]" : "", selName(e.sel), e.cyc),
               obs(e.inst, e.sel), e.val);
    end
  end

  task automatic pushExp(input string tag, input int inst, input int sel, input logic [31:0] v);
    exp_t e;
    e.cyc = cycleNo; e.tag = tag; e.inst = inst; e.sel = sel; e.val = v;
    sbQueue.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    tick();
    reset = 1'b1; mem_ready = 1'b1; zero = 1'b1; op = 7'b1100011;
    pushExp("rst", 0, PCW, 0);  pushExp("rst", 0, IRW, 0);  pushExp("rst", 0, MREQ, 0);
    pushExp("rst", 0, REGW, 0); pushExp("rst", 0, MEMW, 0);
  endtask

  // seqHex holds the expected state codes, first cycle in the lowest nibble.
  task automatic runInstr(input string tag, input logic [6:0] o, input logic z,
                          input logic [31:0] seqHex, input int n, input int pcwAt,
                          input int regwAt, input int memwAt, input int immVal,
                          input int xAt, input int xSel, input int xVal,
                          input int stallAt, input int stallN);
    for (int i = 0; i < n; i++) begin
      int st;
      st = int'(seqHex[4*i +: 4]);
      if (i == stallAt) begin
        for (int s = 0; s < stallN; s++) begin
          tick();
          reset = 1'b0; op = o; zero = z; mem_ready = 1'b0;
          pushExp(tag, 0, ST, st);   pushExp(tag, 0, PCW, 0);  pushExp(tag, 0, IRW, 0);
          pushExp(tag, 0, MEMW, 0);  pushExp(tag, 0, REGW, 0); pushExp(tag, 0, MREQ, 1);
        end
      end
      tick();
      reset = 1'b0; op = o; zero = z; mem_ready = 1'b1;
      pushExp(tag, 0, ST, st);
      pushExp(tag, 0, PCW, (i == 0 || i == pcwAt) ? 1 : 0);
      pushExp(tag, 0, IRW, (i == 0) ? 1 : 0);
      pushExp(tag, 0, REGW, (i == regwAt) ? 1 : 0);
      pushExp(tag, 0, MEMW, (i == memwAt) ? 1 : 0);
      pushExp(tag, 0, TRP, (st == 14) ? 1 : 0);
      pushExp(tag, 0, IMM, immVal);
      if (i == xAt) pushExp(tag, 0, xSel, xVal);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    doReset();
    //        tag      op          z     states    n pcw regw memw imm  xAt xSel   xVal stall
    runInstr("lw",    7'b0000011, 1'b0, 32'h43210, 5, -1,  4,  -1, 0,   4, RES,   1, -1, 0);
    runInstr("sw",    7'b0100011, 1'b0, 32'h5210,  4, -1, -1,   3, 1,   3, ADR,   1, -1, 0);
    runInstr("beqT",  7'b1100011, 1'b1, 32'h910,   3,  2, -1,  -1, 2,   2, ALUOP, 1, -1, 0);
    runInstr("beqF",  7'b1100011, 1'b0, 32'h910,   3, -1, -1,  -1, 2,   2, ALUOP, 1, -1, 0);
    runInstr("rtype", 7'b0110011, 1'b0, 32'h8610,  4, -1,  3,  -1, 0,   2, ALUOP, 2, -1, 0);
    runInstr("ialu",  7'b0010011, 1'b0, 32'h8710,  4, -1,  3,  -1, 0,   2, SRCB,  1, -1, 0);
    runInstr("jal",   7'b1101111, 1'b0, 32'h8A10,  4,  2,  3,  -1, 3,   2, SRCB,  2, -1, 0);
    runInstr("jalr",  7'b1100111, 1'b0, 32'h8CB10, 5,  3,  4,  -1, 0,   3, SRCA,  1, -1, 0);
    runInstr("lui",   7'b0110111, 1'b0, 32'h8D10,  4, -1,  3,  -1, 4,   2, SRCA,  3, -1, 0);
    runInstr("auipc", 7'b0010111, 1'b0, 32'h8D10,  4, -1,  3,  -1, 4,   2, SRCA,  1, -1, 0);
    runInstr("lwStl", 7'b0000011, 1'b0, 32'h43210, 5, -1,  4,  -1, 0,   3, ADR,   1,  0, 2);
    runInstr("swStl", 7'b0100011, 1'b0, 32'h5210,  4, -1, -1,   3, 1,   3, MREQ,  1,  3, 3);

    // Fetch timeout: limit 2 traps on the 4th cycle, limit 15 on the 17th.
    doReset();
    for (int i = 0; i < 17; i++) begin
      tick();
      reset = 1'b0; op = 7'b0000011; mem_ready = 1'b0;
      pushExp("tmo", 1, ST, (i < 3) ? 0 : 14);
      pushExp("tmo", 1, TRP, (i < 3) ? 0 : 1);
      pushExp("tmo", 1, PCW, 0);
      pushExp("tmo", 0, ST, (i < 16) ? 0 : 14);
    end
    for (int i = 0; i < 2; i++) begin
      tick();
      mem_ready = 1'b1;
      pushExp("trapHold", 1, ST, 14);  pushExp("trapHold", 1, PCW, 0);
      pushExp("trapHold", 1, IRW, 0);  pushExp("trapHold", 1, MREQ, 0);
      pushExp("trapHold", 0, TRP, 1);
    end
    doReset();
    tick();
    reset = 1'b0; mem_ready = 1'b0;
    pushExp("postRst", 1, ST, 0); pushExp("postRst", 1, TRP, 0);
    pushExp("postRst", 0, ST, 0); pushExp("postRst", 0, TRP, 0);

    runInstr("illegal", 7'b1111111, 1'b0, 32'hE10, 3, -1, -1, -1, 0, 2, MREQ, 0, -1, 0);
    doReset();

    // Reset during MEMREAD abandons the load without a register write.
    runInstr("abort", 7'b0000011, 1'b0, 32'h210, 3, -1, -1, -1, 0, -1, ST, 0, -1, 0);
    tick();
    reset = 1'b1; mem_ready = 1'b1;
    pushExp("abort", 0, ST, 3); pushExp("abort", 0, REGW, 0); pushExp("abort", 0, MREQ, 0);
    tick();
    reset = 1'b0;
    pushExp("abort", 0, ST, 0); pushExp("abort", 0, REGW, 0); pushExp("abort", 0, TRP, 0);

    tick();
    @(negedge clk);
    #1;
    checkVal("sbDrain", 32'(sbQueue.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM for the multicycle RV32I datapath: a shared ALU, a unified instruction/data memory, and IR / OldPC / ALUOut / Data registers.
- Sequences fetch, decode, execute, memory and writeback over several cycles per instruction.
- Handles variable memory latency through a mem_req/mem_ready handshake.
- Traps on illegal opcodes and on memory timeout. Instantiated beside alu_decoder in the multicycle top.

Parameters:
- MEM_WAIT_LIMIT, 15: maximum stall cycles in any memory state before trapping. 0 disables the timeout. Wait counter is 4 bits.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- op  in  7  opcode, IR[6:0]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory accepts/returns data this cycle
- mem_req  out  1  memory access request
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut
- IRWrite  out  1  load IR and OldPC
- PCWrite  out  1  PC load enable
- MemWrite  out  1  memory store strobe
- RegWrite  out  1  register file write enable
- ResultSrc  out  2  result mux: 00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  ALU A mux: 00 = PC, 01 = OldPC, 10 = rs1, 11 = zero
- ALUSrcB  out  2  ALU B mux: 00 = rs2, 01 = ImmExt, 10 = constant 4
- ALUOp  out  2  to alu_decoder: 00 = add, 01 = sub, 10 = funct-decoded
- ImmSrc  out  3  000 = I, 001 = S, 010 = B, 011 = J, 100 = U
- trap  out  1  controller halted
- state  out  4  current state, debug

Behaviour:
- State register is 4 bits, synchronous reset to FETCH. Wait counter resets to 0.
- Reset assertion mid-instruction abandons the instruction. On that edge the FSM goes to FETCH; trap clears.
- While reset is high, PCWrite, IRWrite, RegWrite, MemWrite and mem_req are forced to 0. After reset all outputs are the FETCH values.
- PCWrite = PCUpdate | (Branch & zero). PCUpdate and Branch are internal.
- Unlisted outputs default to 0. Unlisted selects default to 00.
- ImmSrc is combinational from op in every state: lw/I-ALU/jalr 000, sw 001, beq 010, jal 011, lui/auipc 100, other 000.
- States, their outputs, and next state:
  - FETCH (0): mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, IRWrite=PCUpdate=mem_ready. mem_ready goes to DECODE, otherwise stay.
  - DECODE (1): ALUSrcA=01, ALUSrcB=01 (branch target into ALUOut). Next state by op:
    - 0000011 or 0100011 go to MEMADR
    - 0110011 goes to EXECR
    - 0010011 goes to EXECI
    - 1100011 goes to BEQ
    - 1101111 goes to JAL
    - 1100111 goes to JALRADR
    - 0110111 or 0010111 go to UPPER
    - anything else goes to TRAP
  - MEMADR (2): ALUSrcA=10, ALUSrcB=01. Next is MEMREAD if op[5]=0, MEMWRITE if op[5]=1.
  - MEMREAD (3): mem_req=1, AdrSrc=1. mem_ready goes to MEMWB, otherwise stay.
  - MEMWB (4): ResultSrc=01, RegWrite=1. Next is FETCH.
  - MEMWRITE (5): mem_req=1, AdrSrc=1, MemWrite=mem_ready. mem_ready goes to FETCH, otherwise stay.
  - EXECR (6): ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next is ALUWB.
  - EXECI (7): ALUSrcA=10, ALUSrcB=01, ALUOp=10. Next is ALUWB.
  - ALUWB (8): ResultSrc=00, RegWrite=1. Next is FETCH.
  - BEQ (9): ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next is FETCH.
  - JAL (10): ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCUpdate=1. Next is ALUWB (link = OldPC+4).
  - JALRADR (11): ALUSrcA=10, ALUSrcB=01. Next is JALRJ.
  - JALRJ (12): ResultSrc=00, PCUpdate=1, ALUSrcA=01, ALUSrcB=10. Next is ALUWB.
  - UPPER (13): ALUSrcB=01; ALUSrcA=11 if op[5]=1 (lui), 01 if op[5]=0 (auipc). Next is ALUWB.
  - TRAP (14): all enables 0, trap=1. Held until reset.
  - Code 15 is unused; the FSM goes to TRAP.
- Wait counter:
  - Increments each cycle in FETCH, MEMREAD or MEMWRITE with mem_ready=0.
  - Clears on any state change.
  - When MEM_WAIT_LIMIT≠0, a stall cycle with the counter equal to MEM_WAIT_LIMIT goes to TRAP instead of staying. No write strobe is issued on that cycle.
- mem_ready outside the memory states is ignored.
- Cycle counts with zero wait:
  - lw 5
  - sw, R-type, I-ALU, jal, lui, auipc 4
  - beq 3
  - jalr 5

Test Plan:
- Reset then op=0000011, mem_ready=1 → state sequence 0,1,2,3,4,0. RegWrite=1 only in cycle 5 with ResultSrc=01. IRWrite=1 only in cycle 1.
- op=1100011, zero=1 then zero=0 → PCWrite=1, then 0, in the BEQ cycle. ALUOp=01. 3 cycles each.
- op=0100011, mem_ready low 3 cycles in MEMWRITE → MemWrite=0 while stalled. MemWrite=1 for exactly one cycle with mem_ready. Then FETCH.
- MEM_WAIT_LIMIT=2, mem_ready held 0 in FETCH → TRAP after 3 cycles, trap=1, PCWrite=0. Reset → FETCH, trap=0.
- op=1100111 → states 1,11,12,8,0. PCWrite=1 only in JALRJ. ImmSrc=000. RegWrite in ALUWB.
- op=0110111 vs 0010111 → UPPER with ALUSrcA=11 vs 01, ImmSrc=100. op=1111111 → TRAP. Reset asserted in MEMREAD → FETCH next cycle, no RegWrite.
